// File: rtl/vga_dither_out.sv
// Output stage after the video controller: reduces 8-bit RGB to OUT_BITS per channel
// with 4x4 ordered dithering (optionally rotated per frame), keeping a fixed 2-cycle sync alignment.
module vga_dither_out #(
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          i_r,
    input  logic [7:0]          i_g,
    input  logic [7:0]          i_b,
    input  logic                i_hsync,
    input  logic                i_vsync,
    input  logic                i_hblank,
    input  logic                i_vblank,
    input  logic                i_bypass,
    input  logic                i_temporal,
    output logic [OUT_BITS-1:0] o_r,
    output logic [OUT_BITS-1:0] o_g,
    output logic [OUT_BITS-1:0] o_b,
    output logic                o_hsync,
    output logic                o_vsync,
    output logic                o_hblank,
    output logic                o_vblank,
    output logic [1:0]          o_frame
);

    localparam int DROP = 8 - OUT_BITS;
    // The threshold is 4 bits wide; scale it up or down to span the dropped LSBs.
    localparam int SHL  = (DROP >= 4) ? DROP - 4 : 0;
    localparam int SHR  = (DROP >= 4) ? 0 : 4 - DROP;

    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] frame;
    logic       prev_hblank;
    logic       prev_vblank;
    logic       bypass;
    logic       temporal;

    logic       hblank_rise;
    logic       vblank_rise;
    logic       in_blank;

    assign hblank_rise = i_hblank & ~prev_hblank;
    assign vblank_rise = i_vblank & ~prev_vblank;
    assign in_blank    = i_hblank | i_vblank;

    // Mode bits only change at a frame boundary so a frame is never rendered half-and-half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            frame       <= '0;
            prev_hblank <= 1'b0;
            prev_vblank <= 1'b0;
            bypass      <= 1'b0;
            temporal    <= 1'b0;
        end else begin
            prev_hblank <= i_hblank;
            prev_vblank <= i_vblank;

            if (in_blank) x <= '0;
            else          x <= x + 2'd1;

            if (i_vblank)         y <= '0;
            else if (hblank_rise) y <= y + 2'd1;

            if (vblank_rise) begin
                frame    <= frame + 2'd1;
                bypass   <= i_bypass;
                temporal <= i_temporal;
            end
        end
    end

    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] v;
        case ({row, col})
            4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
            4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
            4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'ha: v = 4'd1;   4'hb: v = 4'd9;
            4'hc: v = 4'd15;  4'hd: v = 4'd7;   4'he: v = 4'd13;  default: v = 4'd5;
        endcase
        return v;
    endfunction

    logic [1:0] xi;
    logic [1:0] yi;
    logic [3:0] t;

    always_comb begin
        xi = x;
        yi = y;
        if (temporal) begin
            xi = x + frame;
            yi = y + frame;
        end
    end

    assign t = bayer(yi, xi);

    logic [7:0] r1;
    logic [7:0] g1;
    logic [7:0] b1;
    logic [3:0] t1;
    logic       hsync1;
    logic       vsync1;
    logic       hblank1;
    logic       vblank1;
    logic       blank1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1      <= '0;
            g1      <= '0;
            b1      <= '0;
            t1      <= '0;
            hsync1  <= 1'b0;
            vsync1  <= 1'b0;
            hblank1 <= 1'b0;
            vblank1 <= 1'b0;
            blank1  <= 1'b0;
        end else begin
            r1      <= i_r;
            g1      <= i_g;
            b1      <= i_b;
            t1      <= t;
            hsync1  <= i_hsync;
            vsync1  <= i_vsync;
            hblank1 <= i_hblank;
            vblank1 <= i_vblank;
            blank1  <= in_blank;
        end
    end

    logic [8:0] d;
    assign d = (9'(t1) << SHL) >> SHR;

    // Saturate before truncating so bright colours never wrap to black.
    function automatic logic [OUT_BITS-1:0] reduce(input logic [7:0] c, input logic [8:0] off,
                                                   input logic byp);
        logic [8:0] sum;
        logic [8:0] sat;
        sum = {1'b0, c} + off;
        sat = sum[8] ? 9'h0ff : sum;
        return byp ? OUT_BITS'(c >> DROP) : OUT_BITS'(sat >> DROP);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_r      <= '0;
            o_g      <= '0;
            o_b      <= '0;
            o_hsync  <= 1'b0;
            o_vsync  <= 1'b0;
            o_hblank <= 1'b0;
            o_vblank <= 1'b0;
        end else begin
            o_r      <= blank1 ? '0 : reduce(r1, d, bypass);
            o_g      <= blank1 ? '0 : reduce(g1, d, bypass);
            o_b      <= blank1 ? '0 : reduce(b1, d, bypass);
            o_hsync  <= hsync1;
            o_vsync  <= vsync1;
            o_hblank <= hblank1;
            o_vblank <= vblank1;
        end
    end

    assign o_frame = frame;

endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: drives synthetic video frames and compares every output cycle
// against a reference model of the dither rules.
module tb_vga_dither_out;

    localparam int OB   = 2;
    localparam int DROP = 8 - OB;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    i_r, i_g, i_b;
    logic          i_hsync, i_vsync, i_hblank, i_vblank, i_bypass, i_temporal;
    logic [OB-1:0] o_r, o_g, o_b;
    logic          o_hsync, o_vsync, o_hblank, o_vblank;
    logic [1:0]    o_frame;

    vga_dither_out #(.OUT_BITS(OB)) dut (
        .clk(clk), .reset(reset),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_hblank(i_hblank), .i_vblank(i_vblank),
        .i_bypass(i_bypass), .i_temporal(i_temporal),
        .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_hblank(o_hblank), .o_vblank(o_vblank),
        .o_frame(o_frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OB-1:0] r;
        logic [OB-1:0] g;
        logic [OB-1:0] b;
        logic          hs;
        logic          vs;
        logic          hb;
        logic          vb;
        logic [1:0]    frame;
    } pix_t;

    pix_t pend[$];
    int   tpend[$];
    pix_t exp_q[$];
    pix_t obs_q[$];
    int   tag_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    int   m_x, m_y, m_frame;
    logic m_byp, m_tmp, m_phb, m_pvb;

    function automatic logic [OB-1:0] chan(input int c, input int d, input logic blank, input logic byp);
        int s;
        if (blank) return '0;
        if (byp) return OB'(c >> DROP);
        s = c + d;
        if (s > 255) s = 255;
        return OB'(s >> DROP);
    endfunction

    task automatic model_clear();
        m_x = 0; m_y = 0; m_frame = 0;
        m_byp = 1'b0; m_tmp = 1'b0; m_phb = 1'b0; m_pvb = 1'b0;
        pend.delete(); tpend.delete();
    endtask

    // Presents one pixel, advances one clock and files the expected/observed pair once the pipe is full.
    task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic hs, input logic vs, input logic hb, input logic vb, input int tag);
        pix_t e, o;
        int f, t, d;
        logic blank;
        i_r = r; i_g = g; i_b = b;
        i_hsync = hs; i_vsync = vs; i_hblank = hb; i_vblank = vb;
        blank = hb | vb;
        f = m_tmp ? m_frame : 0;
        t = bayer[(m_y + f) % 4][(m_x + f) % 4];
        d = (t * (1 << DROP)) / 16;
        e.r = chan(r, d, blank, m_byp);
        e.g = chan(g, d, blank, m_byp);
        e.b = chan(b, d, blank, m_byp);
        e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb; e.frame = 2'd0;
        pend.push_back(e);
        tpend.push_back(tag);
        if (blank) m_x = 0; else m_x = (m_x + 1) % 4;
        if (vb) m_y = 0; else if (hb && !m_phb) m_y = (m_y + 1) % 4;
        if (vb && !m_pvb) begin
            m_frame = (m_frame + 1) % 4;
            m_byp = i_bypass;
            m_tmp = i_temporal;
        end
        m_phb = hb; m_pvb = vb;
        @(posedge clk);
        #1;
        if (pend.size() == 2) begin
            e = pend.pop_front();
            e.frame = 2'(m_frame);
            exp_q.push_back(e);
            tag_q.push_back(tpend.pop_front());
            o.r = o_r; o.g = o_g; o.b = o_b;
            o.hs = o_hsync; o.vs = o_vsync; o.hb = o_hblank; o.vb = o_vblank;
            o.frame = o_frame;
            obs_q.push_back(o);
        end
    endtask

    task automatic line(input int w, input int hbl, input logic vb, input int tagbase, input bit crand,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [7:0] cr, cg, cb;
        for (int i = 0; i < w; i++) begin
            cr = crand ? 8'($urandom_range(0, 255)) : r;
            cg = crand ? 8'($urandom_range(0, 255)) : g;
            cb = crand ? 8'($urandom_range(0, 255)) : b;
            drive(cr, cg, cb, 1'b0, vb, 1'b0, vb, (tagbase >= 0) ? tagbase + i : -1);
        end
        for (int j = 0; j < hbl; j++) begin
            cr = crand ? 8'($urandom_range(0, 255)) : r;
            drive(cr, g, b, (j == 1) || (hbl == 1), vb, 1'b1, vb, -1);
        end
    endtask

    // Visible lines first, then vertical blanking; set_line changes the mode inputs mid-frame.
    task automatic frame(input int w, input int h, input int hbl, input int vbl, input int tagbase,
                         input bit crand, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input int set_line, input logic new_byp, input logic new_tmp);
        for (int y = 0; y < h; y++) begin
            if (y == set_line) begin
                i_bypass = new_byp;
                i_temporal = new_tmp;
            end
            line(w, hbl, 1'b0, (tagbase >= 0) ? tagbase + 4 * y : -1, crand, r, g, b);
        end
        for (int v = 0; v < vbl; v++) line(w, hbl, 1'b1, -1, crand, r, g, b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        exp_q.delete(); obs_q.delete(); tag_q.delete();
    endtask

    task automatic test_reset();
        pix_t e, o;
        int tg;
        logic [3*OB+5:0] outs;
        for (int k = 0; k < 3; k++) drive(8'hF0, 8'hC3, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tg = tag_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL pre_reset tag=%0d: got %h expected %h", tg, o, e);
            else n_pass++;
        end
        #2;
        reset = 1'b1;
        #1;
        outs = {o_r, o_g, o_b, o_hsync, o_vsync, o_hblank, o_vblank, o_frame};
        n_checks++;
        if (outs !== '0) $display("FAIL async_reset: got %h expected 0", outs);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        outs = {o_r, o_g, o_b, o_hsync, o_vsync, o_hblank, o_vblank, o_frame};
        n_checks++;
        if (outs !== '0) $display("FAIL held_reset: got %h expected 0", outs);
        else n_pass++;
        reset = 1'b0;
        model_clear();
        drive(8'h3F, 8'h3F, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        drive(8'h3F, 8'h3F, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tg = tag_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL post_reset tag=%0d: got %h expected %h", tg, o, e);
            else n_pass++;
            if (tg >= 0) begin
                n_checks++;
                if (o.r !== OB'(tg)) $display("FAIL first_pixel_t tag=%0d: got %0d expected %0d", tg, o.r, tg);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bypass();
        pix_t e, o;
        int tg;
        i_bypass = 1'b1;
        i_temporal = 1'b0;
        frame(4, 1, 2, 1, -1, 1'b0, 8'h11, 8'h22, 8'h33, -1, 1'b0, 1'b0);
        frame(4, 2, 2, 1, 0, 1'b0, 8'hC0, 8'h3F, 8'hFF, 1, 1'b0, 1'b0);
        frame(4, 2, 2, 1, -1, 1'b1, 8'h00, 8'h00, 8'h00, -1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tg = tag_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL bypass_stream tag=%0d: got %h expected %h", tg, o, e);
            else n_pass++;
            if (tg >= 0) begin
                n_checks++;
                if ({o.r, o.g, o.b} !== {OB'(3), OB'(0), OB'(3)})
                    $display("FAIL bypass_trunc tag=%0d: got %0d/%0d/%0d expected 3/0/3", tg, o.r, o.g, o.b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_dither_block();
        pix_t e, o;
        int tg, px, py, want;
        frame(4, 4, 2, 1, 0, 1'b0, 8'h50, 8'h50, 8'h50, -1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tg = tag_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL dither_stream tag=%0d: got %h expected %h", tg, o, e);
            else n_pass++;
            if (tg >= 0) begin
                px = tg % 4;
                py = (tg / 4) % 4;
                want = (px % 2 == 0 && py % 2 == 1) ? 2 : 1;
                n_checks++;
                if (o.r !== OB'(want)) $display("FAIL dither_pos (%0d,%0d): got %0d expected %0d", px, py, o.r, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        pix_t e, o;
        int tg;
        frame(4, 4, 2, 1, 0, 1'b0, 8'hFF, 8'hFF, 8'hFF, -1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tg = tag_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL saturate_stream tag=%0d: got %h expected %h", tg, o, e);
            else n_pass++;
            if (tg >= 0) begin
                n_checks++;
                if ({o.r, o.g, o.b} !== {3{OB'(3)}})
                    $display("FAIL saturate tag=%0d: got %0d/%0d/%0d expected 3/3/3", tg, o.r, o.g, o.b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sync_random();
        pix_t e, o;
        int tg;
        for (int k = 0; k < 80; k++)
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tg = tag_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL sync_stream: got %h expected %h", o, e);
            else n_pass++;
            if (o.hb || o.vb) begin
                n_checks++;
                if ({o.r, o.g, o.b} !== '0) $display("FAIL blank_colour: got %h expected 0", {o.r, o.g, o.b});
                else n_pass++;
            end
        end
    endtask

    task automatic test_temporal();
        pix_t e, o;
        int tg, k, want;
        i_bypass = 1'b0;
        i_temporal = 1'b0;
        do_reset();
        for (int f = 0; f < 5; f++)
            frame(4, 2, 2, 1, f * 16, 1'b0, 8'h6C, 8'h6C, 8'h6C, (f == 0) ? 1 : -1, 1'b0, 1'b1);
        line(4, 2, 1'b0, -1, 1'b0, 8'h00, 8'h00, 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tg = tag_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL temporal_stream tag=%0d: got %h expected %h", tg, o, e);
            else n_pass++;
            if (tg >= 0 && tg % 16 == 0) begin
                k = tg / 16;
                want = (k == 3) ? 2 : 1;
                n_checks++;
                if (o.r !== OB'(want)) $display("FAIL temporal_px00 seq=%0d: got %0d expected %0d", k, o.r, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random_frames();
        pix_t e, o;
        int tg, h;
        for (int f = 0; f < 6; f++) begin
            h = $urandom_range(1, 6);
            frame($urandom_range(1, 9), h, $urandom_range(1, 4), $urandom_range(1, 2), -1, 1'b1,
                  8'h00, 8'h00, 8'h00, int'($urandom_range(0, h)) - 1,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tg = tag_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL random_frames: got %h expected %h", o, e);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        i_r = '0; i_g = '0; i_b = '0;
        i_hsync = 1'b0; i_vsync = 1'b0; i_hblank = 1'b0; i_vblank = 1'b0;
        i_bypass = 1'b0; i_temporal = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_bypass();
        test_dither_block();
        test_saturation();
        test_sync_random();
        test_temporal();
        test_random_frames();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_dither_out.md
Name: vga_dither_out

Overview:
- Output stage directly downstream of the video controller. It consumes the controller's blanked 8-bit r/g/b, sync and blank signals.
- It reduces each colour channel to OUT_BITS using 4x4 ordered (Bayer) dithering, with optional per-frame temporal rotation.
- All colour and sync outputs are registered, with a fixed 2-cycle latency.
- Outputs drive the narrow digital RGB pins and keep sync alignment exact.

Parameters:
OUT_BITS, 2, output bits per channel; legal 1..7; DROP = 8-OUT_BITS

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
i_r, i_g, i_b  input  8 each  controller colour (already 0 in blanking)
i_hsync, i_vsync  input  1 each  controller syncs (polarity passed through unchanged)
i_hblank, i_vblank  input  1 each  high during blanking
i_bypass  input  1  1 = plain truncation, no dither
i_temporal  input  1  1 = rotate dither matrix per frame
o_r, o_g, o_b  output  OUT_BITS each  reduced colour
o_hsync, o_vsync, o_hblank, o_vblank  output  1 each  inputs delayed 2 cycles
o_frame  output  2  internal frame counter (debug)

Behaviour:
- Reset is asynchronous: every register clears immediately. All outputs are 0, counters are 0, and both latched mode bits are 0. Normal operation resumes on the first clock edge after reset deasserts.
- Position counters are driven from the input-side signals and update every clock:
  - x[1:0]: cleared on any cycle with i_hblank|i_vblank high; otherwise x+1, wrapping mod 4.
  - y[1:0]: cleared while i_vblank is high. Increments mod 4 on an hblank rising edge (prev i_hblank=0, now 1) while i_vblank is low. The first visible line has y=0.
  - frame[1:0]: increments mod 4 on a vblank rising edge (prev i_vblank=0, now 1).
- The mode bits are latched on the vblank rising edge, on the same cycle frame increments. Changes to i_bypass or i_temporal mid-frame therefore never take effect until the next frame.
- Matrix index:
  - temporal=0: (xi, yi) = (x, y).
  - temporal=1: xi = x+frame mod 4, yi = y+frame mod 4, using the frame value after the increment.
- Bayer matrix, indexed as t = B[yi][xi], values 0..15:
  - row0: 0 8 2 10
  - row1: 12 4 14 6
  - row2: 3 11 1 9
  - row3: 15 7 13 5
- Offset d: if DROP>=4, d = t << (DROP-4); otherwise d = t >> (4-DROP). d is always less than 2^DROP.
- Stage 1 (cycle N+1) registers:
  - i_r, i_g, i_b;
  - t;
  - the four sync/blank inputs;
  - blank1 = i_hblank|i_vblank.
- Stage 2 (cycle N+2), per channel:
  - sum = {1'b0, c} + d, 9 bits.
  - If sum > 255, saturate to 255.
  - Output is sum[7:DROP].
  - In bypass, the output is c[7:DROP] with d ignored.
  - If blank1 is high, the output is forced to 0, regardless of the colour input.
- The sync/blank outputs equal their inputs delayed exactly 2 cycles, bit-exact, with no glitches. They are never gated by bypass or blanking.
- Counters and o_frame keep running regardless of mode.
- Wrap-around:
  - x wraps mod 4 on lines of any length.
  - y wraps mod 4 on frames of any height.
  - frame wraps 3 -> 0.
- Simultaneous hblank and vblank rising on the same cycle: frame increments, y stays cleared (vblank has priority), x clears.

Test Plan:
1. Async reset pulse mid-line with nonzero inputs -> all outputs 0 in the same cycle without waiting for clk; after release, o_frame=0 and the first visible pixel uses t=B[0][0]=0.
2. OUT_BITS=2, bypass latched 1, i_r=0xC0, i_g=0x3F, i_b=0xFF in the visible region -> two cycles later o_r=3, o_g=0, o_b=3.
3. OUT_BITS=2, dither on, constant i_r=0x50 over a 4x4 visible block -> o_r=2 at (x,y) = (0,1), (2,1), (0,3), (2,3) (t>=12); o_r=1 at the other 12 positions.
4. OUT_BITS=2, i_r=0xFF at every t -> o_r=3 everywhere (saturation, never wraps to 0).
5. Toggle i_hblank and i_hsync with a random pattern -> o_hblank and o_hsync equal the inputs delayed 2 cycles; colour is 0 on every cycle where delayed blank is high.
6. OUT_BITS=2, i_temporal raised mid-frame with i_r=0x6C at pixel (0,0) -> no change until the next vblank rise; over the following 4 frames, frame=1,2,3,0 gives t=4,1,5,0 and o_r=1,1,2,1.
